// File: rtl/q5_sweep_controller.sv
// q5_sweep_controller
// Self-checking stimulus sequencer for the 8-bit Q5 datapath. A start pulse
// sweeps every vector 0..LAST_VEC onto dut_in, one per clock. Each response on
// dut_out is compared, DUT_LATENCY cycles later, against the golden function
//   exp[6:0] = v[6:0], exp[7] = v[7] | ~v[6]
// and the controller reports a verdict, an error count and the first failing
// vector.
//
// Ports:
//   clk              in   system clock, all state on the rising edge
//   clear            in   synchronous active-high reset (beats start)
//   start            in   begin a sweep; honoured only in IDLE or DONE
//   dut_in           out  [7:0] stimulus to the circuit under test
//   dut_out          in   [7:0] response from the circuit under test
//   busy             out  high in RUN and DRAIN
//   done             out  high in DONE
//   pass             out  high in DONE when no vector mismatched
//   err_count        out  [8:0] mismatching vectors, saturates at 256
//   first_fail_vec   out  [7:0] stimulus of the first mismatch
//   first_fail_valid out  first_fail_vec holds a captured value
module q5_sweep_controller #(
  parameter int         DUT_LATENCY = 0,     // 0..4 cycles, 0 = combinational DUT
  parameter logic [7:0] LAST_VEC    = 8'hFF
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  output logic [7:0] dut_in,
  input  logic [7:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // DRAIN lasts DUT_LATENCY edges; the counter leaves on its last value.
  localparam int         DRAIN_LAST_I = (DUT_LATENCY > 1) ? DUT_LATENCY - 1 : 0;
  localparam logic [1:0] DRAIN_LAST   = DRAIN_LAST_I[1:0];
  localparam logic [8:0] ERR_MAX      = 9'd256;

  function automatic logic [7:0] golden(input logic [7:0] v);
    return {v[7] | ~v[6], v[6:0]};
  endfunction

  state_e     state_q, state_d;
  logic [7:0] dut_in_q, dut_in_d;
  logic [1:0] drain_q, drain_d;
  logic [8:0] err_q, err_d;
  logic [7:0] ffv_q, ffv_d;
  logic       ffvalid_q, ffvalid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       issue_vld;
  logic       cmp_vld;
  logic [7:0] cmp_vec;
  logic       mismatch;

  // A vector is being issued during every RUN cycle.
  assign issue_vld = (state_q == S_RUN);

  if (DUT_LATENCY == 0) begin : g_comb
    assign cmp_vld = issue_vld;
    assign cmp_vec = dut_in_q;
  end else begin : g_pipe
    logic [DUT_LATENCY-1:0] vld_pipe_q;
    logic [7:0]             vec_pipe_q [DUT_LATENCY];

    // Delay line aligning each issued vector with its DUT response.
    always_ff @(posedge clk) begin
      if (clear) begin
        vld_pipe_q <= '0;
        for (int k = 0; k < DUT_LATENCY; k++) vec_pipe_q[k] <= 8'h00;
      end else begin
        vld_pipe_q[0] <= issue_vld;
        vec_pipe_q[0] <= dut_in_q;
        for (int k = 1; k < DUT_LATENCY; k++) begin
          vld_pipe_q[k] <= vld_pipe_q[k-1];
          vec_pipe_q[k] <= vec_pipe_q[k-1];
        end
      end
    end

    assign cmp_vld = vld_pipe_q[DUT_LATENCY-1];
    assign cmp_vec = vec_pipe_q[DUT_LATENCY-1];
  end

  assign mismatch = cmp_vld && (dut_out != golden(cmp_vec));

  // Next-state, stimulus and scoreboard update.
  always_comb begin
    state_d   = state_q;
    dut_in_d  = dut_in_q;
    drain_d   = drain_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;

    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 9'd1;
      end
      if (!ffvalid_q) begin
        ffv_d     = cmp_vec;
        ffvalid_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // No compare is pending here, so clearing the scoreboard is safe.
        if (start) begin
          state_d   = S_RUN;
          dut_in_d  = 8'h00;
          drain_d   = 2'd0;
          err_d     = 9'd0;
          ffv_d     = 8'h00;
          ffvalid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (dut_in_q == LAST_VEC) begin
          // dut_in holds LAST_VEC; it is never wrapped.
          state_d = (DUT_LATENCY > 0) ? S_DRAIN : S_DONE;
          drain_d = 2'd0;
        end else begin
          dut_in_d = dut_in_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == 9'd0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_IDLE;
      dut_in_q  <= 8'h00;
      drain_q   <= 2'd0;
      err_q     <= 9'd0;
      ffv_q     <= 8'h00;
      ffvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dut_in_q  <= dut_in_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign dut_in           = dut_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_q5_sweep_controller.sv
// Bench for q5_sweep_controller: a table of model variants swept through a
// default-parameter instance, plus hand-written sequences for clear, ignored
// start, restart from DONE, DUT_LATENCY=2 and a short LAST_VEC.
module tb_q5_sweep_controller;

  logic clk;
  logic clear;
  int   n_checks;
  int   n_fail;

  // Instance A: defaults, model selected by mode.
  logic       start_a, busy_a, done_a, pass_a, ffvalid_a;
  logic [7:0] dut_in_a, dut_out_a, ffv_a;
  logic [8:0] err_a;
  logic [2:0] mode;
  logic [7:0] ma1, ma2;

  // Instance B: DUT_LATENCY=2 with a twice-registered correct model.
  logic       start_b, busy_b, done_b, pass_b, ffvalid_b;
  logic [7:0] dut_in_b, dut_out_b, ffv_b;
  logic [8:0] err_b;
  logic [7:0] mb1, mb2;

  // Instance C: LAST_VEC=0x0F with a correct combinational model.
  logic       start_c, busy_c, done_c, pass_c, ffvalid_c;
  logic [7:0] dut_in_c, dut_out_c, ffv_c;
  logic [8:0] err_c;

  function automatic logic [7:0] ref_fn(input logic [7:0] v);
    logic [7:0] r;
    r[6:0] = v[6:0];
    r[7]   = v[7] | ~v[6];
    return r;
  endfunction

  q5_sweep_controller u_dut (
    .clk(clk), .clear(clear), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffvalid_a)
  );

  q5_sweep_controller #(.DUT_LATENCY(2)) u_dut_l2 (
    .clk(clk), .clear(clear), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffvalid_b)
  );

  q5_sweep_controller #(.LAST_VEC(8'h0F)) u_dut_l15 (
    .clk(clk), .clear(clear), .start(start_c), .dut_in(dut_in_c), .dut_out(dut_out_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_vec(ffv_c), .first_fail_valid(ffvalid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Student-circuit models.
  always @(posedge clk) begin
    ma1 <= ref_fn(dut_in_a);
    ma2 <= ma1;
    mb1 <= ref_fn(dut_in_b);
    mb2 <= mb1;
  end

  always_comb begin
    dut_out_a = ref_fn(dut_in_a);
    case (mode)
      3'd0: dut_out_a = ref_fn(dut_in_a);
      3'd1: dut_out_a = ref_fn(dut_in_a) & 8'h7F;
      3'd2: dut_out_a = {dut_in_a[7] | dut_in_a[6], dut_in_a[6:0]};
      3'd3: dut_out_a = ref_fn(dut_in_a) ^ ((dut_in_a == 8'h37) ? 8'h01 : 8'h00);
      3'd4: dut_out_a = ma2;
      default: dut_out_a = ref_fn(dut_in_a);
    endcase
  end

  assign dut_out_b = mb2;
  assign dut_out_c = ref_fn(dut_in_c);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sweep instance A from the current negedge; returns edges after the start
  // edge until done, busy samples and dut_in sequencing errors.
  task automatic run_main(output int edges, output int busy_cnt, output int seq_bad);
    edges = 0; busy_cnt = 0; seq_bad = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (!done_a && edges < 2000) begin
      if (busy_a) begin
        busy_cnt++;
        if (dut_in_a != edges[7:0]) seq_bad++;
      end
      @(negedge clk);
      edges++;
    end
  endtask

  typedef struct {
    logic [2:0] mode;
    int         exp_err;
    logic [7:0] exp_ffv;
    logic       exp_ffvalid;
    logic       exp_pass;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, busy_cnt, seq_bad, n;

    n_checks = 0; n_fail = 0;
    tbl[0] = '{3'd0,   0, 8'h00, 1'b0, 1'b1};
    tbl[1] = '{3'd1, 192, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{3'd2, 128, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{3'd3,   1, 8'h37, 1'b1, 1'b0};
    tbl[4] = '{3'd4, 256, 8'h00, 1'b1, 1'b0};

    mode = 3'd0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    clear = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dut_in", dut_in_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_ffv", ffv_a, 0);
    check("rst_ffvalid", ffvalid_a, 0);
    clear = 1'b0;
    @(negedge clk);

    // Table of model variants on the default instance.
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_main(edges, busy_cnt, seq_bad);
      check($sformatf("v%0d_edges", i), edges, 256);
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, 256);
      check($sformatf("v%0d_seq", i), seq_bad, 0);
      check($sformatf("v%0d_done", i), done_a, 1);
      check($sformatf("v%0d_busy_end", i), busy_a, 0);
      check($sformatf("v%0d_dut_in_hold", i), dut_in_a, 8'hFF);
      check($sformatf("v%0d_pass", i), pass_a, tbl[i].exp_pass);
      check($sformatf("v%0d_err", i), err_a, tbl[i].exp_err);
      check($sformatf("v%0d_ffv", i), ffv_a, tbl[i].exp_ffv);
      check($sformatf("v%0d_ffvalid", i), ffvalid_a, tbl[i].exp_ffvalid);
      @(negedge clk);
    end

    // Start during RUN is ignored.
    mode = 3'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (dut_in_a != 8'h10 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ign_reach_10", n, 16);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("ign_dut_in_next", dut_in_a, 8'h11);
    check("ign_busy", busy_a, 1);
    edges = 17;
    while (!done_a && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
    check("ign_edges", edges, 256);
    check("ign_pass", pass_a, 1);
    check("ign_err", err_a, 0);

    // Clear mid-sweep, with a faulty model so counters are nonzero.
    mode = 3'd1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (dut_in_a != 8'h64 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("clr_reach_64", n, 100);
    check("clr_err_before", (err_a != 9'd0), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_dut_in", dut_in_a, 0);
    check("clr_busy", busy_a, 0);
    check("clr_done", done_a, 0);
    check("clr_pass", pass_a, 0);
    check("clr_err", err_a, 0);
    check("clr_ffv", ffv_a, 0);
    check("clr_ffvalid", ffvalid_a, 0);
    repeat (3) @(negedge clk);
    check("clr_stays_idle", {busy_a, done_a, dut_in_a}, 0);

    // Sweep to DONE with errors, then restart with a correct model.
    mode = 3'd1;
    run_main(edges, busy_cnt, seq_bad);
    check("rs_err_192", err_a, 192);
    check("rs_done", done_a, 1);
    mode = 3'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("rs_err_clr", err_a, 0);
    check("rs_ffvalid_clr", ffvalid_a, 0);
    check("rs_ffv_clr", ffv_a, 0);
    check("rs_done_clr", done_a, 0);
    check("rs_pass_clr", pass_a, 0);
    check("rs_busy", busy_a, 1);
    check("rs_dut_in", dut_in_a, 0);
    edges = 0;
    while (!done_a && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
    check("rs_edges", edges, 256);
    check("rs_pass", pass_a, 1);

    // DUT_LATENCY=2 with a matching registered model.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    edges = 0;
    while (!done_b && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
    check("l2_edges", edges, 258);
    check("l2_pass", pass_b, 1);
    check("l2_err", err_b, 0);
    check("l2_ffvalid", ffvalid_b, 0);
    check("l2_ffv", ffv_b, 0);
    check("l2_busy", busy_b, 0);
    check("l2_dut_in", dut_in_b, 8'hFF);

    // LAST_VEC=0x0F.
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    edges = 0;
    while (!done_c && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
    check("l15_edges", edges, 16);
    check("l15_pass", pass_c, 1);
    check("l15_err", err_c, 0);
    check("l15_ffvalid", ffvalid_c, 0);
    check("l15_ffv", ffv_c, 0);
    check("l15_busy", busy_c, 0);
    check("l15_dut_in", dut_in_c, 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
